// File: rtl/parity_check_arbiter.sv
// Round-robin scheduler that shares one external even-parity checker among
// NREQ requesters. Each accepted word is driven to the checker for one cycle.
// The checker's error flag is captured and returned as a tagged result.
// A saturating error counter is kept alongside.
module parity_check_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 5,
  parameter int unsigned CNTW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [DW-1:0]           chk_data,
  input  logic                    chk_err,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_err,
  output logic [CNTW-1:0]         err_cnt,
  input  logic                    err_clr
);

  localparam int unsigned     IDW      = $clog2(NREQ);
  localparam logic [IDW-1:0]  LAST_RST = IDW'(NREQ - 1);
  localparam logic [CNTW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  last_grant_q, last_grant_d;
  logic [DW-1:0]   chk_data_q, chk_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_err_q, res_err_d;
  logic            res_valid_q, res_valid_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  logic [DW-1:0]   words [NREQ];
  logic [IDW-1:0]  cand;
  logic            grant_vld;
  logic [IDW-1:0]  grant_idx;
  logic [NREQ-1:0] grant_oh;

  // Unpack the flat request bus into one word per requester
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DW +: DW];
  end

  // Round-robin pick: first valid requester after the last one served
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(last_grant_q) + k) % NREQ);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Next-state and accept-strobe decode
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    chk_data_d   = chk_data_q;
    res_id_d     = res_id_q;
    res_err_d    = res_err_q;
    res_valid_d  = res_valid_q;
    err_cnt_d    = err_cnt_q;
    grant_oh     = '0;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          grant_oh[grant_idx] = 1'b1;
          chk_data_d          = words[grant_idx];
          res_id_d            = grant_idx;
          state_d             = CHECK;
        end
      end
      CHECK: begin
        res_err_d   = chk_err;
        res_valid_d = 1'b1;
        if (chk_err && (err_cnt_q != CNT_MAX)) begin
          err_cnt_d = err_cnt_q + CNTW'(1);
        end
        state_d = REPORT;
      end
      REPORT: begin
        if (res_ready) begin
          res_valid_d  = 1'b0;
          last_grant_d = res_id_q;
          state_d      = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

    // Clear takes priority over a coincident increment
    if (err_clr) begin
      err_cnt_d = '0;
    end
  end

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      chk_data_q   <= '0;
      res_id_q     <= '0;
      res_err_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      chk_data_q   <= chk_data_d;
      res_id_q     <= res_id_d;
      res_err_q    <= res_err_d;
      res_valid_q  <= res_valid_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Accept strobe is suppressed while reset is held
  assign req_ready = rst ? '0 : grant_oh;
  assign chk_data  = chk_data_q;
  assign res_id    = res_id_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Testbench for parity_check_arbiter: a transaction-level model is checked against the DUT every cycle,
// with directed scenarios plus randomized traffic.
module tb_parity_check_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned DW      = 5;
  localparam int unsigned CNTW    = 8;
  localparam int unsigned IDW     = $clog2(NREQ);
  localparam int          CNT_MAX = (1 << CNTW) - 1;

  logic                 clk       = 1'b0;
  logic                 rst       = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*DW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        chk_data;
  logic                 chk_err;
  logic                 res_valid;
  logic                 res_ready = 1'b1;
  logic [IDW-1:0]       res_id;
  logic                 res_err;
  logic [CNTW-1:0]      err_cnt;
  logic                 err_clr   = 1'b0;

  int checks = 0;
  int errors = 0;

  // Model of the transaction in flight
  bit            m_busy = 1'b0;
  int            m_age  = 0;
  int            m_id   = 0;
  logic [DW-1:0] m_word = '0;
  int            m_err  = 0;
  int            m_cnt  = 0;
  int            m_last = NREQ - 1;

  logic [NREQ-1:0] exp_rr;
  logic [NREQ-1:0] rr_s;

  parity_check_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .chk_data  (chk_data),
    .chk_err   (chk_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_err   (res_err),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  // The shared external even-parity checker
  assign chk_err = ^chk_data;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input int last, input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int d = 1; d <= NREQ; d++) begin
      if (r < 0 && v[(last + d) % NREQ]) r = (last + d) % NREQ;
    end
    return r;
  endfunction

  function automatic int odd_ones(input logic [DW-1:0] w);
    return $countones(w) % 2;
  endfunction

  // Model update on every clock edge, reset is asynchronous
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_id = 0; m_word = '0;
      m_err = 0; m_cnt = 0; m_last = NREQ - 1;
    end else begin
      if (!m_busy) begin
        if (req_valid != '0) begin
          m_id   = pick(m_last, req_valid);
          m_word = req_data[m_id*DW +: DW];
          m_busy = 1'b1;
          m_age  = 1;
        end
      end else if (m_age == 1) begin
        m_err = odd_ones(m_word);
        if (m_err != 0) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        m_age = 2;
      end else if (res_ready) begin
        m_busy = 1'b0;
        m_last = m_id;
      end
      if (err_clr) m_cnt = 0;
    end
  end

  // Compare every output against the model on each falling edge
  initial forever begin
    @(negedge clk);
    exp_rr = '0;
    if (!rst && !m_busy && req_valid != '0) exp_rr[pick(m_last, req_valid)] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("res_valid", 32'(res_valid), 32'(m_busy && m_age >= 2));
    chk("res_id",    32'(res_id),    m_id);
    chk("res_err",   32'(res_err),   m_err);
    chk("chk_data",  32'(chk_data),  32'(m_word));
    chk("err_cnt",   32'(err_cnt),   m_cnt);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait for accept, drop valid, wait for the result
  task automatic send(input int id, input logic [DW-1:0] w);
    int n;
    req_data[id*DW +: DW] = w;
    req_valid[id] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[id] && n < 50) begin @(negedge clk); n++; end
    chk("accept_seen", 32'(req_ready[id]), 32'd1);
    step();
    req_valid[id] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 50) begin @(negedge clk); n++; end
    chk("result_seen", 32'(res_valid), 32'd1);
  endtask

  initial begin
    int got [8];
    int n;
    logic [IDW-1:0] hold_id;
    logic hold_err;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // First word after reset goes to requester 0, even parity
    req_data[0 +: DW] = 5'b00011;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t1_check_no_res", 32'(res_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'd1);
    chk("t1_res_id",    32'(res_id),    32'd0);
    chk("t1_res_err",   32'(res_err),   32'd0);
    chk("t1_err_cnt",   32'(err_cnt),   32'd0);
    step();

    // Odd-parity word on requester 2
    send(2, 5'b00111);
    chk("t2_res_id",  32'(res_id),  32'd2);
    chk("t2_res_err", 32'(res_err), 32'd1);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    step();

    // Grant order with every requester held valid
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = DW'(1 << i);
    req_valid = '1;
    n = 0;
    for (int c = 0; c < 80 && n < 8; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) got[n] = i;
        n++;
      end
      step();
    end
    req_valid = '0;
    chk("t3_grants", 32'(n), 32'd8);
    for (int j = 0; j < 8; j++) chk("t3_order", got[j], j % NREQ);
    step(); step();
    @(negedge clk);
    chk("t3_err_cnt", 32'(err_cnt), 32'd8);
    step();

    // Result back-pressure while other requesters wait
    res_ready = 1'b0;
    send(1, 5'b10110);
    hold_id  = res_id;
    hold_err = res_err;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        req_valid = 4'b1101;
        req_data  = 20'h5a5a5;
      end
      @(negedge clk);
      chk("t4_hold_valid", 32'(res_valid), 32'd1);
      chk("t4_hold_id",    32'(res_id),    32'd1);
      chk("t4_hold_err",   32'(res_err),   32'd1);
      chk("t4_hold_same",  32'({res_id, res_err}), 32'({hold_id, hold_err}));
      chk("t4_no_ready",   32'(req_ready), 32'd0);
    end
    step();
    res_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("t4_still_valid", 32'(res_valid), 32'd1);
    step();
    @(negedge clk);
    chk("t4_retired", 32'(res_valid), 32'd0);
    step();

    // Saturation of the error counter
    for (int w = 0; w < 260; w++) begin
      send(w % NREQ, 5'b11100);
      step();
    end
    @(negedge clk);
    chk("t5_saturated", 32'(err_cnt), 32'(CNT_MAX));
    step();

    // Clear coincident with an errored CHECK
    req_data[0 +: DW] = 5'b00001;
    req_valid[0] = 1'b1;
    @(negedge clk);
    chk("t5c_ready", 32'(req_ready[0]), 32'd1);
    step();
    req_valid[0] = 1'b0;
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("t5c_cleared", 32'(err_cnt),   32'd0);
    chk("t5c_res_err", 32'(res_err),   32'd1);
    chk("t5c_valid",   32'(res_valid), 32'd1);
    step();

    // Asynchronous reset during CHECK
    send(1, 5'b00001);
    step();
    req_data[2*DW +: DW] = 5'b10101;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("t6_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_req_ready", 32'(req_ready), 32'd0);
    chk("t6_rst_res_valid", 32'(res_valid), 32'd0);
    chk("t6_rst_chk_data",  32'(chk_data),  32'd0);
    chk("t6_rst_res_id",    32'(res_id),    32'd0);
    chk("t6_rst_res_err",   32'(res_err),   32'd0);
    chk("t6_rst_err_cnt",   32'(err_cnt),   32'd0);
    step();
    rst = 1'b0;
    req_data[0 +: DW]      = 5'b00011;
    req_data[3*DW +: DW]   = 5'b01111;
    req_valid = 4'b1001;
    @(negedge clk);
    chk("t6_first_after_rst", 32'(req_ready), 32'b0001);
    step();
    req_valid[0] = 1'b0;
    step(); step();
    send(3, 5'b01111);
    chk("t6_second_id", 32'(res_id), 32'd3);
    step();

    // Every 5-bit word on requester 1
    for (int w = 0; w < 32; w++) begin
      logic [DW-1:0] wv;
      wv = DW'(w);
      send(1, wv);
      chk("t7_sweep", 32'(res_err), 32'(odd_ones(wv)));
      step();
    end

    // Randomized traffic that obeys the hold-until-ready rule
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      rr_s = req_ready;
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (rr_s[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 99) < 35);
          req_data[i*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 99) < 4) begin
          req_valid[i] = 1'b0;
        end
      end
      res_ready = ($urandom_range(0, 99) < 60);
      err_clr   = ($urandom_range(0, 99) < 3);
    end
    req_valid = '0;
    res_ready = 1'b1;
    err_clr   = 1'b0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
